// File: rtl/bit_collector8_pkg.sv
// Shared constants and types for the bit_collector8 serial-to-parallel stage.
package bit_collector8_pkg;
   localparam int WORD_W = 8;
   localparam int CNT_W  = 3;

   // Output FSM encoding (legacy-compatible plain constants)
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Count value at which the next accepted bit completes a word
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/bit_collector8_if.sv
// Handshake bundle between the bit producer/word consumer (master) and the
// collector (slave). out_parity exists only when BIT_COLLECTOR_PARITY_EN is defined.
interface bit_collector8_if;
   import bit_collector8_pkg::*;

   logic             in_bit;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   word_t            out_word;
   logic             out_all_ones;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] bit_count;
`ifdef BIT_COLLECTOR_PARITY_EN
   logic             out_parity;
`endif

   modport master (
      output in_bit, in_valid, flush, out_ready,
      input  in_ready, out_word, out_all_ones, out_valid,
`ifdef BIT_COLLECTOR_PARITY_EN
      input  out_parity,
`endif
      input  bit_count
   );

   modport slave (
      input  in_bit, in_valid, flush, out_ready,
      output in_ready, out_word, out_all_ones, out_valid,
`ifdef BIT_COLLECTOR_PARITY_EN
      output out_parity,
`endif
      output bit_count
   );
endinterface

// File: rtl/bit_collector8_ctrl.sv
// bit_collector_ctrl: bit counter, two-state output FSM and the
// accept/completion/in_ready decisions for bit_collector8.
module bit_collector_ctrl
   import bit_collector8_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   input  logic             flush_i,
   input  logic             out_ready_i,
   output logic             in_ready_o,
   output logic             accept_o,
   output logic             complete_o,
   output logic             out_valid_o,
   output logic [CNT_W-1:0] bit_count_o
);
   logic [CNT_W-1:0] count_q, count_d;
   logic [0:0]       state_q, state_d;
   logic             at_last;

   assign at_last     = (count_q == CNT_LAST);
   // Only the completing bit must wait for the consumer; bits 0..6 always fit.
   assign in_ready_o  = !(at_last && (state_q == ST_FULL) && !out_ready_i);
   // A flush in the same cycle drops the bit, so it is never an accept.
   assign accept_o    = in_valid_i && in_ready_o && !flush_i;
   assign complete_o  = accept_o && at_last;
   assign out_valid_o = (state_q == ST_FULL);
   assign bit_count_o = count_q;

   // Next bit count: flush clears, accept advances (7 wraps to 0).
   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (accept_o) begin
         count_d = count_q + 1'b1;
      end
   end

   // Output FSM: a completion always lands in FULL, so a take plus a new word is bubble-free.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (complete_o) state_d = ST_FULL;
         ST_FULL:  if (out_ready_i && !complete_o) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Counter and state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         state_q <= ST_EMPTY;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
      end
   end
endmodule

// File: rtl/bit_collector8.sv
// bit_collector8: collects serial bits LSB-first into 8-bit words and holds
// each completed word with a registered all-ones flag for the AND consumer.
// Optional feature macro: BIT_COLLECTOR_PARITY_EN adds a registered out_parity.
module bit_collector8
   import bit_collector8_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   bit_collector8_if.slave    bus
);
   logic [WORD_W-2:0] shift_q, shift_d;
   word_t             word_q;
   word_t             word_next;
   logic              all_ones_q;
   logic              accept;
   logic              complete;
`ifdef BIT_COLLECTOR_PARITY_EN
   logic              parity_q;
`endif

   bit_collector_ctrl u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (bus.in_valid),
      .flush_i     (bus.flush),
      .out_ready_i (bus.out_ready),
      .in_ready_o  (bus.in_ready),
      .accept_o    (accept),
      .complete_o  (complete),
      .out_valid_o (bus.out_valid),
      .bit_count_o (bus.bit_count)
   );

   // Each partial-word bit loads only when the count points at it; bit 7
   // never needs storage because it goes straight into the output word.
   generate
      for (genvar gi = 0; gi < WORD_W - 1; gi++) begin : g_shift
         assign shift_d[gi] = (accept && (bus.bit_count == CNT_W'(gi))) ? bus.in_bit : shift_q[gi];
      end
   endgenerate

   assign word_next = {bus.in_bit, shift_q};

   // Partial-word register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   // Output word and its reductions change only on completion, so they stay stable while held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q     <= '0;
         all_ones_q <= 1'b0;
      end else if (complete) begin
         word_q     <= word_next;
         all_ones_q <= &word_next;
      end
   end

`ifdef BIT_COLLECTOR_PARITY_EN
   // Parity register, loaded together with the output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else if (complete) begin
         parity_q <= ^word_next;
      end
   end
   assign bus.out_parity = parity_q;
`endif

   assign bus.out_word     = word_q;
   assign bus.out_all_ones = all_ones_q;
endmodule
